// File: rtl/cnn_stream_pkg.sv
// Shared types for the CNN pixel-stream blocks: reader FSM states and the
// per-pixel frame/row marker sideband that travels alongside each pixel.
package cnn_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stream_state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } stream_marker_t;

   localparam int MARKER_WIDTH = $bits(stream_marker_t);

   function automatic stream_marker_t make_marker(input logic first_pixel,
                                                  input logic last_col,
                                                  input logic last_pixel);
      stream_marker_t m;
      m.sof = first_pixel;
      m.eol = last_col;
      m.eof = last_pixel;
      return m;
   endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO that catches RAM read data so a stalled consumer never loses
// a pixel. The head entry only changes on a pop, keeping the output stable.
module stream_skid_buffer #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic [1:0]       count_q;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   // slot0 is always the head; slot1 holds the second entry when full.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         slot0   <= '0;
         slot1   <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  slot0 <= push_data;
               end else begin
                  slot1 <= push_data;
               end
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               slot0   <= slot1;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head_valid = (count_q != 2'd0);
   assign head_data  = slot0;
   assign count      = count_q;

endmodule

// File: rtl/image_stream_reader.sv
// Walks a row-major image in a 1-cycle-latency RAM and emits it as a
// valid/ready raster stream with sof/eol/eof markers.
module image_stream_reader
   import cnn_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  sof,
   output logic                  eol,
   output logic                  eof
);

   localparam int PIXELS        = IMG_WIDTH * IMG_HEIGHT;
   localparam int COL_WIDTH     = $clog2(IMG_WIDTH + 1);
   localparam int ROW_WIDTH     = $clog2(IMG_HEIGHT + 1);
   localparam int PAYLOAD_WIDTH = DATA_WIDTH + MARKER_WIDTH;

   stream_state_t             state;
   stream_state_t             state_next;
   logic [ADDR_WIDTH-1:0]     addr;
   logic [COL_WIDTH-1:0]      col;
   logic [ROW_WIDTH-1:0]      row;
   logic                      inflight;
   stream_marker_t            inflight_marker;
   stream_marker_t            issue_marker;
   logic                      issue;
   logic                      pop;
   logic                      last_addr;
   logic                      last_col;
   logic [2:0]                occupancy;

   logic                      skid_valid;
   logic [PAYLOAD_WIDTH-1:0]  skid_head;
   logic [1:0]                skid_count;
   logic [DATA_WIDTH-1:0]     head_pixel;
   stream_marker_t            head_marker;

   assign pop          = skid_valid && ready_in;
   assign last_addr    = (addr == ADDR_WIDTH'(PIXELS - 1));
   assign last_col     = (col == COL_WIDTH'(IMG_WIDTH - 1));
   assign occupancy    = {1'b0, skid_count} + {2'b00, inflight};
   assign issue_marker = make_marker((row == '0) && (col == '0), last_col, last_addr);

   // A read may issue only if its data is guaranteed a skid slot on return.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            issue = (occupancy < 3'd2) || ((occupancy == 3'd2) && pop);
            if (issue && last_addr) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_marker.eof) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Counters park at zero after the last read so the next frame starts clean.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         addr            <= '0;
         col             <= '0;
         row             <= '0;
         inflight        <= 1'b0;
         inflight_marker <= '0;
         done            <= 1'b0;
      end else begin
         state    <= state_next;
         done     <= (state == DRAIN) && (state_next == IDLE);
         inflight <= issue;
         if (issue) begin
            inflight_marker <= issue_marker;
            if (last_addr) begin
               addr <= '0;
               col  <= '0;
               row  <= '0;
            end else begin
               addr <= addr + ADDR_WIDTH'(1);
               if (last_col) begin
                  col <= '0;
                  row <= row + ROW_WIDTH'(1);
               end else begin
                  col <= col + COL_WIDTH'(1);
               end
            end
         end
      end
   end

   stream_skid_buffer #(
      .WIDTH(PAYLOAD_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({mem_rdata, inflight_marker}),
      .pop       (pop),
      .head_valid(skid_valid),
      .head_data (skid_head),
      .count     (skid_count)
   );

   assign head_pixel  = skid_head[PAYLOAD_WIDTH-1:MARKER_WIDTH];
   assign head_marker = stream_marker_t'(skid_head[MARKER_WIDTH-1:0]);

   assign busy      = (state != IDLE);
   assign mem_en    = issue;
   assign mem_addr  = addr;
   assign valid_out = skid_valid;
   assign pixel_out = skid_valid ? head_pixel : '0;
   assign sof       = skid_valid && head_marker.sof;
   assign eol       = skid_valid && head_marker.eol;
   assign eof       = skid_valid && head_marker.eof;

endmodule

// File: tb/tb_image_stream_reader.sv
// Randomised bench for image_stream_reader on a 4x3 frame: a scoreboard expects
// beat i of every frame to be RAM[i] with markers derived from i.
module tb_image_stream_reader;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int AW = $clog2(N);
   localparam logic [5:0] READY_PATTERN = 6'b101001;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          valid_out;
   logic          ready_in;
   logic [DW-1:0] pixel_out;
   logic          sof;
   logic          eol;
   logic          eof;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] ram [N];

   int beat_idx = 0;
   int issued = 0;
   int done_count = 0;
   int frames_done = 0;
   int ready_mode = 0;
   int pat_idx = 0;
   logic mon_pop;
   logic prev_stall = 1'b0;
   logic [DW+2:0] prev_beat = '0;

   int first_valid;
   int done_cyc;
   int beats;
   int waited;
   int base_done;
   int base_frames;

   always #5 clk = ~clk;

   image_stream_reader #(
      .DATA_WIDTH(DW),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .mem_en   (mem_en),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .valid_out(valid_out),
      .ready_in (ready_in),
      .pixel_out(pixel_out),
      .sof      (sof),
      .eol      (eol),
      .eof      (eof)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= (int'(mem_addr) < N) ? ram[int'(mem_addr)] : '0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic fillRam(input bit random_data);
      for (int i = 0; i < N; i++) begin
         ram[i] = random_data ? DW'($urandom) : DW'(i);
      end
   endtask

   task automatic pulseStart();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int bound);
      waited = 0;
      while (done !== 1'b1 && waited < bound) begin
         @(negedge clk);
         waited++;
      end
      checkOutput(tag, 32'(waited < bound), 1);
   endtask

   task automatic applyStimulus(input int mode);
      ready_mode = mode;
      pulseStart();
      waitDone("done_within_bound", 400);
      @(posedge clk);
      #1;
   endtask

   // Consumer model: mode 0 always ready, mode 1 fixed stall pattern, mode 2 random.
   initial begin
      ready_in = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: begin
               ready_in = READY_PATTERN[pat_idx];
               pat_idx  = (pat_idx + 1) % 6;
            end
            2: ready_in = ($urandom_range(0, 3) != 0);
            default: ready_in = 1'b1;
         endcase
      end
   end

   // Scoreboard: reads must walk 0..N-1 with at most two outstanding pixels,
   // and accepted beats must be RAM[0..N-1] with markers derived from position.
   always @(negedge clk) begin
      if (!rst) begin
         mon_pop = valid_out && ready_in;
         if (!valid_out) begin
            checkOutput("idle_markers", 32'({sof, eol, eof}), 0);
         end
         if (prev_stall) begin
            checkOutput("stall_stable", 32'({valid_out, pixel_out, sof, eol, eof}), 32'({1'b1, prev_beat}));
         end
         if (mem_en) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(issued));
            checkOutput("addr_below_n", 32'(issued < N), 1);
            checkOutput("read_occupancy", 32'((issued + 1 - beat_idx - int'(mon_pop)) <= 2), 1);
            issued++;
         end
         if (mon_pop) begin
            checkOutput("pixel", 32'(pixel_out), 32'(ram[beat_idx]));
            checkOutput("markers", 32'({sof, eol, eof}),
                        32'({beat_idx == 0, (beat_idx % W) == W - 1, beat_idx == N - 1}));
            if (beat_idx == N - 1) begin
               beat_idx = 0;
               issued   = 0;
               frames_done++;
            end else begin
               beat_idx++;
            end
         end
         prev_stall = valid_out && !ready_in;
         prev_beat  = {pixel_out, sof, eol, eof};
         if (done) begin
            done_count++;
         end
      end
   end

   initial begin
      #300000;
      failures++;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      fillRam(0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_outputs",
                  32'({busy, done, mem_en, mem_addr, valid_out, pixel_out, sof, eol, eof}), 0);

      // Ramp frame with ready held high: check latency and gap-free streaming.
      ready_mode = 0;
      pulseStart();
      first_valid = -1;
      done_cyc    = -1;
      beats       = 0;
      for (int cyc = 1; cyc <= N + 6; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            checkOutput("start_response", 32'({busy, mem_en, mem_addr}), 32'({2'b11, AW'(0)}));
         end
         if (valid_out && first_valid < 0) first_valid = cyc;
         if (valid_out && ready_in) beats++;
         if (done && done_cyc < 0) begin
            done_cyc = cyc;
            checkOutput("busy_at_done", 32'(busy), 0);
         end
      end
      checkOutput("first_beat_latency", 32'(first_valid), 3);
      checkOutput("done_latency", 32'(done_cyc), N + 3);
      checkOutput("beat_count", 32'(beats), N);
      @(posedge clk);
      #1;

      base_done   = done_count;
      base_frames = frames_done;
      applyStimulus(1);
      checkOutput("bp_frames", 32'(frames_done - base_frames), 1);
      checkOutput("bp_done", 32'(done_count - base_done), 1);

      for (int f = 0; f < 4; f++) begin
         fillRam(1);
         base_frames = frames_done;
         applyStimulus(2);
         checkOutput("random_frame", 32'(frames_done - base_frames), 1);
      end

      // A second start mid-frame must not spawn another frame.
      base_done   = done_count;
      base_frames = frames_done;
      ready_mode  = 2;
      pulseStart();
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      checkOutput("busy_during_restart", 32'(busy), 1);
      @(posedge clk);
      #1 start = 1'b0;
      waitDone("busy_start_done", 400);
      repeat (2 * N + 20) @(posedge clk);
      #1;
      checkOutput("busy_start_frames", 32'(frames_done - base_frames), 1);
      checkOutput("busy_start_dones", 32'(done_count - base_done), 1);
      checkOutput("busy_start_idle", 32'(busy), 0);

      // Back-to-back: start raised in the done cycle.
      fillRam(1);
      base_done   = done_count;
      base_frames = frames_done;
      ready_mode  = 0;
      pulseStart();
      waitDone("b2b_first_done", 100);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      first_valid = -1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            checkOutput("b2b_restart", 32'({busy, mem_en, mem_addr}), 32'({2'b11, AW'(0)}));
         end
         if (valid_out && first_valid < 0) begin
            first_valid = cyc;
            checkOutput("b2b_sof", 32'(sof), 1);
         end
      end
      checkOutput("b2b_latency", 32'(first_valid), 3);
      waitDone("b2b_second_done", 100);
      @(posedge clk);
      #1;
      checkOutput("b2b_frames", 32'(frames_done - base_frames), 2);
      checkOutput("b2b_dones", 32'(done_count - base_done), 2);

      // Abort at beat 5, then confirm a clean restart.
      fillRam(0);
      ready_mode = 0;
      base_done  = done_count;
      pulseStart();
      waited = 0;
      while (!(valid_out && pixel_out == DW'(5)) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("reached_beat5", 32'(waited < 100), 1);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      beat_idx   = 0;
      issued     = 0;
      prev_stall = 1'b0;
      @(negedge clk);
      checkOutput("abort_outputs",
                  32'({busy, done, mem_en, mem_addr, valid_out, pixel_out, sof, eol, eof}), 0);
      repeat (N + 5) @(posedge clk);
      #1;
      checkOutput("abort_no_done", 32'(done_count - base_done), 0);
      base_done   = done_count;
      base_frames = frames_done;
      applyStimulus(0);
      checkOutput("restart_frames", 32'(frames_done - base_frames), 1);
      checkOutput("restart_dones", 32'(done_count - base_done), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
